// File: rtl/sram_access_arbiter_if.sv
// Purpose: bundles the VGA requester, CPU requester and SRAM port signals of
//          sram_access_arbiter into one interface.
// Modports:
//   slave  - arbiter view: request inputs in, acks/rdata/SRAM strobes/owner out
//   master - environment view (requesters and SRAM model), directions mirrored
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [3:0]        vga_byte_sel;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;

  logic              cpu_req;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_byte_sel;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_byte_sel;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_ren;
  logic              sram_wen;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_busy;

  logic [1:0]        owner;

  modport slave (
    input  vga_req, vga_addr, vga_byte_sel,
    output vga_ack, vga_rdata,
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_sel,
    output cpu_ack, cpu_rdata,
    output sram_addr, sram_byte_sel, sram_wdata, sram_ren, sram_wen,
    input  sram_rdata, sram_busy,
    output owner
  );

  modport master (
    output vga_req, vga_addr, vga_byte_sel,
    input  vga_ack, vga_rdata,
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_sel,
    input  cpu_ack, cpu_rdata,
    input  sram_addr, sram_byte_sel, sram_wdata, sram_ren, sram_wen,
    output sram_rdata, sram_busy,
    input  owner
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Purpose: shares one SRAM port between the VGA framebuffer fetch and the CPU
//          load/store path. VGA has priority; a starvation counter forces a CPU
//          grant after STARVE_LIMIT consecutive VGA grants with the CPU waiting.
//          Each access walks IDLE -> ACC -> ACK and ends with a 1-cycle ack.
// Ports:
//   clk  - system clock, posedge
//   rst  - synchronous active-high reset
//   bus  - sram_access_arbiter_if.slave: VGA/CPU request+ack+rdata, SRAM
//          address/data/strobes, SRAM rdata/busy, owner (00 none, 01 VGA, 10 CPU)
module sram_access_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_access_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACK} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_VGA  = 2'b01;
  localparam logic [1:0] OWN_CPU  = 2'b10;
  localparam int         CW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] W_LIMIT = CW'(STARVE_LIMIT);

  state_t            r_state, w_next;
  logic [1:0]        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_sel;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic [DATA_W-1:0] r_vga_rdata, r_cpu_rdata;
  logic [CW-1:0]     r_starve;

  logic w_req_any, w_cpu_win;

  assign w_req_any = bus.vga_req | bus.cpu_req;
  // VGA wins by default; CPU only when alone or once the starve limit is hit.
  assign w_cpu_win = bus.cpu_req & (~bus.vga_req | (r_starve == W_LIMIT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next = S_ACC;
      S_ACC:   if (!bus.sram_busy) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant latch, read-data capture and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_NONE;
      r_addr      <= '0;
      r_sel       <= '0;
      r_wdata     <= '0;
      r_wen       <= 1'b0;
      r_vga_rdata <= '0;
      r_cpu_rdata <= '0;
      r_starve    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req_any) begin
          if (w_cpu_win) begin
            r_owner <= OWN_CPU;
            r_addr  <= bus.cpu_addr;
            r_sel   <= bus.cpu_byte_sel;
            r_wdata <= bus.cpu_wdata;
            r_wen   <= bus.cpu_wen;
          end else begin
            r_owner <= OWN_VGA;
            r_addr  <= bus.vga_addr;
            r_sel   <= bus.vga_byte_sel;
            r_wdata <= '0;
            r_wen   <= 1'b0;
          end
        end
        S_ACC: if (!bus.sram_busy && !r_wen) begin
          if (r_owner == OWN_CPU) r_cpu_rdata <= bus.sram_rdata;
          else                    r_vga_rdata <= bus.sram_rdata;
        end
        S_ACK:   r_owner <= OWN_NONE;
        default: ;
      endcase

      // Counts VGA grants taken while the CPU is waiting; saturating.
      if (!bus.cpu_req)
        r_starve <= '0;
      else if (r_state == S_IDLE && w_req_any) begin
        if (w_cpu_win)               r_starve <= '0;
        else if (r_starve != W_LIMIT) r_starve <= r_starve + CW'(1);
      end
    end
  end

  // Outputs: SRAM side only driven in ACC, acks only in ACK
  always_comb begin
    bus.sram_addr     = '0;
    bus.sram_byte_sel = '0;
    bus.sram_wdata    = '0;
    bus.sram_ren      = 1'b0;
    bus.sram_wen      = 1'b0;
    bus.vga_ack       = 1'b0;
    bus.cpu_ack       = 1'b0;
    case (r_state)
      S_ACC: begin
        bus.sram_addr     = r_addr;
        bus.sram_byte_sel = r_sel;
        bus.sram_wdata    = r_wdata;
        bus.sram_ren      = ~r_wen;
        bus.sram_wen      = r_wen;
      end
      S_ACK: begin
        bus.vga_ack = (r_owner == OWN_VGA);
        bus.cpu_ack = (r_owner == OWN_CPU);
      end
      default: ;
    endcase
  end

  assign bus.owner     = r_owner;
  assign bus.vga_rdata = r_vga_rdata;
  assign bus.cpu_rdata = r_cpu_rdata;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Testbench for sram_access_arbiter: directed reset/latency/busy/starvation/abort
// scenarios plus randomized concurrent VGA/CPU traffic. A transaction-level model
// predicts each grant and pushes the expected access into a queue; a monitor pops
// and compares against the SRAM strobes and the acks.
module tb_sram_access_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          is_cpu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- SRAM model (16 words, configurable busy length) ----------
  logic [31:0] sram_mem [16];
  bit          mem_init = 0;
  bit          in_acc   = 0;
  int          busy_left = 0;
  int          lat_cfg  = -1;   // <0: random 0..3 busy cycles per access

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) sram_mem[i] = 32'hA5A50000 + i;
      mem_init = 1;
    end
    if (bus.sram_ren || bus.sram_wen) begin
      if (!in_acc) begin
        in_acc    = 1;
        busy_left = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end else if (busy_left > 0) busy_left--;
    end else begin
      in_acc    = 0;
      busy_left = 0;
    end
    bus.sram_busy  = (busy_left > 0);
    bus.sram_rdata = bus.sram_busy ? $urandom : sram_mem[bus.sram_addr[3:0]];
    // Write lands on the final (not busy) cycle of the access.
    if (bus.sram_wen && !bus.sram_busy)
      for (int b = 0; b < 4; b++)
        if (bus.sram_byte_sel[b]) sram_mem[bus.sram_addr[3:0]][8*b +: 8] = bus.sram_wdata[8*b +: 8];
  end

  // ---------------- reference model: predicts every grant ---------------------
  logic [31:0] ref_mem [16];
  bit          ref_init = 0;
  int          m_starve = 0;
  bit          m_busy   = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!ref_init) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A50000 + i;
      ref_init = 1;
    end
    if (rst) begin
      exp_q.delete();
      m_busy   = 0;
      m_starve = 0;
    end else begin
      if (!bus.cpu_req) m_starve = 0;
      if (!m_busy && (bus.vga_req || bus.cpu_req)) begin
        e.is_cpu = bus.cpu_req && (!bus.vga_req || m_starve == LIM);
        if (e.is_cpu) begin
          e.wen = bus.cpu_wen; e.addr = bus.cpu_addr; e.wdata = bus.cpu_wdata; e.sel = bus.cpu_byte_sel;
          m_starve = 0;
        end else begin
          e.wen = 0; e.addr = bus.vga_addr; e.wdata = 0; e.sel = bus.vga_byte_sel;
          if (bus.cpu_req && m_starve < LIM) m_starve++;
        end
        if (e.wen)
          for (int b = 0; b < 4; b++)
            if (e.sel[b]) ref_mem[e.addr[3:0]][8*b +: 8] = e.wdata[8*b +: 8];
        e.rdata = ref_mem[e.addr[3:0]];
        exp_q.push_back(e);
        m_busy = 1;
      end
      if (bus.vga_ack || bus.cpu_ack) m_busy = 0;
    end
  end

  // ---------------- monitor ----------------------------------------------------
  logic [31:0] exp_vga = '0;
  logic [31:0] exp_cpu = '0;

  always @(negedge clk) begin
    exp_t h;
    if (rst) begin
      exp_vga = '0;
      exp_cpu = '0;
    end else begin
      if (bus.vga_ack || bus.cpu_ack) chk("ack_excl", 64'(bus.vga_ack & bus.cpu_ack), 0);
      if (bus.sram_ren || bus.sram_wen) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL strobe_unexp: got ren=%0b wen=%0b expected no access", bus.sram_ren, bus.sram_wen);
        end else begin
          h = exp_q[0];
          chk("sram_ren",  64'(bus.sram_ren), 64'(!h.wen));
          chk("sram_wen",  64'(bus.sram_wen), 64'(h.wen));
          chk("sram_addr", 64'(bus.sram_addr), 64'(h.addr));
          chk("sram_sel",  64'(bus.sram_byte_sel), 64'(h.sel));
          if (h.wen) chk("sram_wdata", 64'(bus.sram_wdata), 64'(h.wdata));
          chk("owner_acc", 64'(bus.owner), h.is_cpu ? 64'd2 : 64'd1);
        end
      end else if (bus.vga_ack || bus.cpu_ack) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL ack_unexp: got vga_ack=%0b cpu_ack=%0b expected none", bus.vga_ack, bus.cpu_ack);
        end else begin
          h = exp_q.pop_front();
          chk("ack_who",   64'(bus.cpu_ack), 64'(h.is_cpu));
          chk("owner_ack", 64'(bus.owner), h.is_cpu ? 64'd2 : 64'd1);
          if (!h.wen) begin
            if (h.is_cpu) exp_cpu = h.rdata;
            else          exp_vga = h.rdata;
          end
          chk("vga_rdata", 64'(bus.vga_rdata), 64'(exp_vga));
          chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(exp_cpu));
        end
      end else begin
        chk("owner_idle", 64'(bus.owner), 0);
      end
    end
  end

  // ---------------- stimulus helpers ------------------------------------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // which: 0 VGA, 1 CPU, 2 either. Returns at the negedge of the ack cycle.
  task automatic wait_ack(int which, output bit ok, output bit was_cpu);
    ok = 0; was_cpu = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which != 1 && bus.vga_ack) || (which != 0 && bus.cpu_ack)) begin
        ok = 1; was_cpu = bus.cpu_ack; break;
      end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: got no ack in 200 cycles expected ack (which=%0d)", which);
    end
  endtask

  task automatic cpu_access(bit wen, logic [31:0] addr, logic [31:0] wdata, logic [3:0] sel);
    bit ok, wc;
    bus.cpu_wen = wen; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_byte_sel = sel;
    bus.cpu_req = 1;
    wait_ack(1, ok, wc);
    cyc();
    bus.cpu_req = 0;
  endtask

  task automatic vga_drv(int n);
    bit ok, wc;
    for (int i = 0; i < n; i++) begin
      int idle = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (idle > 0) begin
        bus.vga_req = 0;
        repeat (idle) cyc();
      end
      bus.vga_addr = $urandom_range(0, 15); bus.vga_byte_sel = 4'($urandom);
      bus.vga_req  = 1;
      wait_ack(0, ok, wc);
      if (!ok) break;
      cyc();
    end
    bus.vga_req = 0;
  endtask

  task automatic cpu_drv(int n);
    bit ok, wc;
    for (int i = 0; i < n; i++) begin
      int idle = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (idle > 0) begin
        bus.cpu_req = 0;
        repeat (idle) cyc();
      end
      bus.cpu_wen = 1'($urandom); bus.cpu_addr = $urandom_range(0, 15);
      bus.cpu_wdata = $urandom; bus.cpu_byte_sel = 4'($urandom);
      bus.cpu_req = 1;
      wait_ack(1, ok, wc);
      if (!ok) break;
      cyc();
    end
    bus.cpu_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence --------------------------------------------
  initial begin
    int nw, na;
    bit ok, wc;
    bus.vga_req = 1; bus.vga_addr = 32'd1; bus.vga_byte_sel = 4'hF;
    bus.cpu_req = 1; bus.cpu_wen = 1; bus.cpu_addr = 32'd2;
    bus.cpu_wdata = 32'h55; bus.cpu_byte_sel = 4'hF;

    // T1: reset held two cycles with both requests active
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_vga_ack",   64'(bus.vga_ack), 0);
    chk("t1_cpu_ack",   64'(bus.cpu_ack), 0);
    chk("t1_ren",       64'(bus.sram_ren), 0);
    chk("t1_wen",       64'(bus.sram_wen), 0);
    chk("t1_owner",     64'(bus.owner), 0);
    chk("t1_vga_rdata", 64'(bus.vga_rdata), 0);
    chk("t1_cpu_rdata", 64'(bus.cpu_rdata), 0);
    chk("t1_sram_addr", 64'(bus.sram_addr), 0);
    cyc();
    rst = 0; bus.vga_req = 0; bus.cpu_req = 0;
    cyc();

    // T2: lone VGA read of addr 5 holding DEADBEEF, no busy
    lat_cfg = 0;
    cpu_access(1, 32'd5, 32'hDEADBEEF, 4'hF);
    bus.vga_addr = 32'd5; bus.vga_byte_sel = 4'hF; bus.vga_req = 1;  // cycle N
    @(negedge clk);
    chk("t2_n_ren",    64'(bus.sram_ren), 0);
    @(negedge clk);
    chk("t2_n1_ren",   64'(bus.sram_ren), 1);
    chk("t2_n1_addr",  64'(bus.sram_addr), 5);
    @(negedge clk);
    chk("t2_n2_ack",   64'(bus.vga_ack), 1);
    chk("t2_n2_rdata", 64'(bus.vga_rdata), 64'h DEADBEEF);
    cyc();
    bus.vga_req = 0;

    // T3: CPU write with busy high 3 cycles; cpu_rdata primed with a read first
    cpu_access(0, 32'd5, 32'd0, 4'hF);
    lat_cfg = 3;
    bus.cpu_wen = 1; bus.cpu_addr = 32'd7; bus.cpu_wdata = 32'h12345678;
    bus.cpu_byte_sel = 4'b1111; bus.cpu_req = 1;
    nw = 0; na = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nw += int'(bus.sram_wen);
      na += int'(bus.cpu_ack);
      if (bus.cpu_ack) break;
    end
    chk("t3_wen_cycles", 64'(nw), 4);
    chk("t3_ack_count",  64'(na), 1);
    chk("t3_cpu_rdata",  64'(bus.cpu_rdata), 64'h DEADBEEF);
    cyc();
    bus.cpu_req = 0;
    @(negedge clk);
    chk("t3_no_reack", 64'(bus.cpu_ack), 0);
    lat_cfg = 0;
    bus.vga_addr = 32'd7; bus.vga_req = 1;   // read back through the scoreboard
    wait_ack(0, ok, wc);
    cyc();
    bus.vga_req = 0;
    cyc();

    // T4/T6: both requests held, re-requesting right after each ack
    bus.vga_addr = $urandom_range(0, 15); bus.vga_req = 1;
    bus.cpu_wen = 0; bus.cpu_addr = $urandom_range(0, 15); bus.cpu_req = 1;
    for (int k = 0; k < 15; k++) begin
      wait_ack(2, ok, wc);
      if (!ok) break;
      chk("t4_order", 64'(wc), 64'(k % 5 == 4));
      cyc();
      if (wc) bus.cpu_addr = $urandom_range(0, 15);
      else    bus.vga_addr = $urandom_range(0, 15);
    end
    bus.vga_req = 0; bus.cpu_req = 0;
    cyc();

    // Random concurrent traffic with random busy lengths
    lat_cfg = -1;
    fork
      vga_drv(40);
      cpu_drv(40);
    join
    repeat (3) cyc();

    // T5: reset while an access is stalled in ACC
    lat_cfg = 10;
    bus.vga_addr = 32'd3; bus.vga_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_acc", 64'(bus.sram_ren), 1);
    cyc(); cyc();
    rst = 1; bus.vga_req = 0;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t5_ren",   64'(bus.sram_ren), 0);
    chk("t5_wen",   64'(bus.sram_wen), 0);
    chk("t5_owner", 64'(bus.owner), 0);
    na = 0;
    for (int i = 0; i < 4; i++) begin
      na += int'(bus.vga_ack | bus.cpu_ack);
      @(negedge clk);
    end
    chk("t5_no_ack", 64'(na), 0);
    lat_cfg = 0;
    cyc();
    bus.vga_addr = 32'd3; bus.vga_req = 1;   // recovery access after abort
    wait_ack(0, ok, wc);
    cyc();
    bus.vga_req = 0;
    repeat (3) cyc();

    chk("q_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
